// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch (I) and load/store (D); D wins ties unless I has
// waited through MAX_D_STREAK D grants. Define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy,
  output logic                timeout_err
);
  localparam int BE_W = DATA_W/8;
  localparam int SW   = $clog2(MAX_D_STREAK+1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          force_i;
  logic          abort;

  // I is forced only when it is actually waiting and D has used up its streak
  assign force_i = i_req && (streak == SW'(MAX_D_STREAK));
  assign d_gnt   = (state == IDLE) && d_req && !force_i;
  assign i_gnt   = (state == IDLE) && i_req && !d_gnt;
  assign busy    = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] tcnt;

  // abort in the cycle the count would reach TIMEOUT; a same-cycle ack still completes
  assign abort = busy && !m_ack && (tcnt == TW'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE)
        tcnt <= '0;
      else if (!m_ack)
        tcnt <= tcnt + 1'b1;
      if (abort)
        timeout_err <= 1'b1;
    end
  end
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      streak   <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (d_gnt) begin
            state   <= BUSY_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_be    <= d_be;
            if (!i_req)
              streak <= '0;
            else if (streak != SW'(MAX_D_STREAK))
              streak <= streak + 1'b1;
          end else if (i_gnt) begin
            state   <= BUSY_I;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_be    <= {BE_W{1'b1}};
            streak  <= '0;
          end
        end
        BUSY_I: begin
          if (m_ack || abort) begin
            state    <= IDLE;
            m_req    <= 1'b0;
            i_rvalid <= 1'b1;
            i_rdata  <= m_ack ? m_rdata : '0;
          end
        end
        BUSY_D: begin
          if (m_ack || abort) begin
            state    <= IDLE;
            m_req    <= 1'b0;
            d_rvalid <= 1'b1;
            // a completed store leaves the last load data in place
            if (!m_ack)
              d_rdata <= '0;
            else if (!m_we)
              d_rdata <= m_rdata;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: arbitration table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, m_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [3:0]    d_be;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy, timeout_err;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_be;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic i_r;
    logic d_r;
    logic exp_i;
    logic exp_d;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0;
    step(); step();
    rst = 1'b0;
  endtask

  // reference model state (transaction level)
  int            mstate;     // 0 free, 1 fetch outstanding, 2 data outstanding
  int            streak;
  int            wait_left;
  logic          e_iv, e_dv, e_we;
  logic [DW-1:0] e_ird, e_drd, e_wd;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_be;

  initial begin
    vec_t vecs[4];
    int   exp_ord[6];
    int   got, pg;
    bit   ip, dp;

    vecs[0] = '{i_r: 1'b0, d_r: 1'b0, exp_i: 1'b0, exp_d: 1'b0};
    vecs[1] = '{i_r: 1'b1, d_r: 1'b0, exp_i: 1'b1, exp_d: 1'b0};
    vecs[2] = '{i_r: 1'b0, d_r: 1'b1, exp_i: 1'b0, exp_d: 1'b1};
    vecs[3] = '{i_r: 1'b1, d_r: 1'b1, exp_i: 1'b0, exp_d: 1'b1};
    exp_ord = '{2, 2, 2, 2, 1, 2};

    do_reset();
    chk("rst_m_req", m_req, 0);     chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);   chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_be", m_be, 0);       chk("rst_busy", busy, 0);
    chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_i_gnt", i_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);

    // idle arbitration table; requests withdrawn before the edge so nothing is granted
    for (int k = 0; k < 4; k++) begin
      i_req = vecs[k].i_r; d_req = vecs[k].d_r;
      #1;
      chk("tbl_i_gnt", i_gnt, vecs[k].exp_i);
      chk("tbl_d_gnt", d_gnt, vecs[k].exp_d);
      i_req = 0; d_req = 0;
      step();
      chk("tbl_no_busy", busy, 0);
    end

    // single fetch
    i_req = 1; i_addr = 32'h100;
    #1; chk("f_i_gnt", i_gnt, 1); chk("f_d_gnt", d_gnt, 0);
    step(); i_req = 0;
    chk("f_m_req", m_req, 1); chk("f_m_addr", m_addr, 32'h100);
    chk("f_m_we", m_we, 0);   chk("f_m_be", m_be, 4'hf); chk("f_busy", busy, 1);
    m_ack = 1; m_rdata = 32'hDEADBEEF;
    step(); m_ack = 0;
    chk("f_i_rvalid", i_rvalid, 1); chk("f_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("f_busy_done", busy, 0);    chk("f_m_req_done", m_req, 0);
    step();
    chk("f_i_rvalid_pulse", i_rvalid, 0);

    // simultaneous requests
    i_req = 1; i_addr = 32'h180; d_req = 1; d_we = 0; d_addr = 32'h1000;
    #1; chk("s_d_gnt", d_gnt, 1); chk("s_i_gnt", i_gnt, 0);
    step(); d_req = 0;
    chk("s_m_addr_d", m_addr, 32'h1000);
    m_ack = 1; m_rdata = 32'hCAFE0001;
    step(); m_ack = 0;
    chk("s_d_rvalid", d_rvalid, 1); chk("s_d_rdata", d_rdata, 32'hCAFE0001);
    #1; chk("s_i_gnt_c2", i_gnt, 1);
    step(); i_req = 0;
    chk("s_m_addr_i", m_addr, 32'h180);
    m_ack = 1; m_rdata = 32'hCAFE0002;
    step(); m_ack = 0;
    chk("s_i_rvalid", i_rvalid, 1); chk("s_i_rdata", i_rdata, 32'hCAFE0002);

    // starvation: I waits while D keeps requesting
    do_reset();
    i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
    for (int k = 0; k < 6; k++) begin
      #1;
      got = i_gnt ? 1 : (d_gnt ? 2 : 0);
      chk("starve_order", got, exp_ord[k]);
      step();
      if (got == 1) i_req = 0;
      if (k == 5) d_req = 0;
      m_ack = 1; m_rdata = 32'h11112222;
      step(); m_ack = 0;
    end

    // store with 3-cycle memory latency; d_rdata must keep the previous load data
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011;
    #1; chk("st_d_gnt", d_gnt, 1);
    step(); d_req = 0; d_we = 0;
    for (int c = 1; c <= 3; c++) begin
      chk("st_m_req", m_req, 1);   chk("st_m_we", m_we, 1);
      chk("st_m_be", m_be, 4'b0011); chk("st_m_addr", m_addr, 32'h2000);
      chk("st_m_wdata", m_wdata, 32'h12345678);
      chk("st_d_rvalid_early", d_rvalid, 0);
      if (c == 3) begin m_ack = 1; m_rdata = 32'hBAD0BAD0; end
      step();
    end
    m_ack = 0;
    chk("st_d_rvalid", d_rvalid, 1); chk("st_d_rdata_kept", d_rdata, 32'h11112222);

    // ack while idle is ignored
    m_ack = 1; m_rdata = 32'h0BADF00D;
    step(); m_ack = 0;
    chk("sp_busy", busy, 0); chk("sp_i_rvalid", i_rvalid, 0); chk("sp_d_rvalid", d_rvalid, 0);

    // reset in the middle of a load, coinciding with m_ack
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    #1; chk("rm_d_gnt", d_gnt, 1);
    step(); d_req = 0;
    step();
    rst = 1; m_ack = 1; m_rdata = 32'h77777777;
    step(); rst = 0; m_ack = 0;
    chk("rm_m_req", m_req, 0); chk("rm_busy", busy, 0); chk("rm_d_rvalid", d_rvalid, 0);
    step();
    chk("rm_d_rvalid_later", d_rvalid, 0);
    d_req = 1; d_addr = 32'h3004;
    #1; chk("rm_regrant", d_gnt, 1);
    step(); d_req = 0;
    chk("rm_m_addr", m_addr, 32'h3004);
    m_ack = 1; m_rdata = 32'h55AA55AA;
    step(); m_ack = 0;
    chk("rm_d_rdata", d_rdata, 32'h55AA55AA);

`ifdef MEM_ARB_TIMEOUT_EN
    d_req = 1; d_we = 0; d_addr = 32'h500;
    #1; chk("to_d_gnt", d_gnt, 1);
    step(); d_req = 0;
    for (int c = 1; c <= 8; c++) begin
      chk("to_m_req", m_req, 1);
      step();
    end
    chk("to_d_rvalid", d_rvalid, 1); chk("to_d_rdata", d_rdata, 0);
    chk("to_m_req_off", m_req, 0);   chk("to_err", timeout_err, 1);
    step(); step();
    chk("to_err_sticky", timeout_err, 1);
    do_reset();
    chk("to_err_cleared", timeout_err, 0);
`endif

    // randomized run against the reference model
    do_reset();
    mstate = 0; streak = 0; wait_left = 0;
    e_iv = 0; e_dv = 0; e_ird = '0; e_drd = '0; e_we = 0; e_wd = '0; e_addr = '0; e_be = '0;
    ip = 0; dp = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("r_m_req", m_req, mstate != 0);
      chk("r_busy", busy, mstate != 0);
      chk("r_i_rvalid", i_rvalid, e_iv);
      chk("r_d_rvalid", d_rvalid, e_dv);
      if (e_iv) chk("r_i_rdata", i_rdata, e_ird);
      if (e_dv) chk("r_d_rdata", d_rdata, e_drd);
      if (mstate != 0) begin
        chk("r_m_addr", m_addr, e_addr);
        chk("r_m_we", m_we, e_we);
        chk("r_m_be", m_be, e_be);
        if (e_we) chk("r_m_wdata", m_wdata, e_wd);
      end

      if (!ip) begin
        if ($urandom_range(0, 9) < 6) begin ip = 1; i_addr = $urandom; end
      end else if ($urandom_range(0, 31) == 0) ip = 0;
      if (!dp) begin
        if ($urandom_range(0, 9) < 5) begin
          dp = 1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
          d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 31) == 0) dp = 0;
      i_req = ip; d_req = dp;

      if (mstate != 0) begin
        if (wait_left == 0) m_ack = 1;
        else begin m_ack = 0; wait_left--; end
      end else m_ack = ($urandom_range(0, 7) == 0);
      m_rdata = $urandom;
      #1;

      pg = 0;
      if (mstate == 0) begin
        if (d_req && !(i_req && streak == MAXS)) pg = 2;
        else if (i_req) pg = 1;
      end
      chk("r_i_gnt", i_gnt, pg == 1);
      chk("r_d_gnt", d_gnt, pg == 2);

      e_iv = 0; e_dv = 0;
      if (pg == 2) begin
        mstate = 2; e_addr = d_addr; e_we = d_we; e_wd = d_wdata; e_be = d_be;
        streak = i_req ? ((streak < MAXS) ? streak + 1 : streak) : 0;
        dp = 0; wait_left = $urandom_range(0, 3);
      end else if (pg == 1) begin
        mstate = 1; e_addr = i_addr; e_we = 0; e_be = 4'hf;
        streak = 0; ip = 0; wait_left = $urandom_range(0, 3);
      end else if (mstate != 0 && m_ack) begin
        if (mstate == 1) begin e_iv = 1; e_ird = m_rdata; end
        else begin e_dv = 1; if (!e_we) e_drd = m_rdata; end
        mstate = 0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
